apb1_root_master: RTL and testbench

// - APB4 initiator for the apb1 subsystem: turns a single-outstanding valid/ready request into one APB transfer on the root bus.
// - Drives the root side of the apb1 leaf decode fabric and returns read data and error status on a valid/ready response channel.
// - Sits between the on-chip bus-to-APB front end and the apb1 leaf mux.

---
 rtl/apb1_root_master.sv | 265 ++++++++++++++++++++++++++
 tb/tb_apb1_root_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb1_root_master.sv
// ----------------------------------------------------------------------------
// apb1_root_master
//
// APB4 initiator for the apb1 subsystem. It takes one request at a time from
// the bus-to-APB front end over a valid/ready channel, runs exactly one APB
// transfer on the root bus that feeds the apb1 leaf mux, and returns the
// result on a valid/ready response channel. Only one transfer is ever
// outstanding: a new request is accepted only after the previous response
// has been handshaken.
//
// Transfer sequence: IDLE -> SETUP -> ACCESS (stays while pready=0) -> RESP
// -> IDLE. All outputs are registered, so reset drives every output to 0.
// The minimum transfer time is 4 cycles.
//
// Optional feature (compile-time macro APB1_MASTER_TIMEOUT_EN):
//   When the macro is defined, an ACCESS phase that sees pready low for
//   TIMEOUT_CYCLES cycles is aborted. The response then reports err=1,
//   timeout=1 and rdata=0. If pready rises in the last allowed cycle, the
//   normal completion wins. When the macro is not defined, ACCESS waits for
//   pready indefinitely and o_rsp_timeout stays 0.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles with pready low before an abort (2..255).
//                   Only has an effect with APB1_MASTER_TIMEOUT_EN.
//   TO_CNT_W        Timeout counter width; 2**TO_CNT_W must exceed
//                   TIMEOUT_CYCLES.
//
// Ports:
//   i_pclk, i_prst        clock and synchronous active-high reset
//   i_req_*/o_req_ready   request channel (addr, write, wdata, wstrb, prot)
//   o_rsp_*/i_rsp_ready   response channel (rdata, err, timeout)
//   o_root_*              APB outputs (psel, paddr, penable, pwdata, pstrb,
//                         pwrite, pprot)
//   i_root_*              APB inputs (pready, pslverr, prdata)
// ----------------------------------------------------------------------------
module apb1_root_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_CNT_W       = 8
) (
    input  logic        i_pclk,
    input  logic        i_prst,

    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_write,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    input  logic [2:0]  i_req_prot,

    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,

    output logic        o_root_psel,
    output logic [31:0] o_root_paddr,
    output logic        o_root_penable,
    output logic [31:0] o_root_pwdata,
    output logic [3:0]  o_root_pstrb,
    output logic        o_root_pwrite,
    output logic [2:0]  o_root_pprot,
    input  logic        i_root_pready,
    input  logic        i_root_pslverr,
    input  logic [31:0] i_root_prdata
);

    // ------------------------------------------------------------------------
    // Elaboration-time check of the timeout configuration.
    // ------------------------------------------------------------------------
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255) ||
        ((2 ** TO_CNT_W) <= TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("apb1_root_master: illegal TIMEOUT_CYCLES / TO_CNT_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        req_ready_q, req_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [2:0]  prot_q, prot_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;

    // High in the ACCESS cycle that must abort if pready is still low.
    logic        to_expire;

`ifdef APB1_MASTER_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

    assign to_expire = (state_q == ST_ACCESS) && (to_cnt_q == TO_LAST);

    // Counts ACCESS cycles with pready low. It is cleared whenever a new
    // transfer enters SETUP, so it never needs to saturate: it can reach at
    // most TIMEOUT_CYCLES, which fits in TO_CNT_W bits.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d == ST_SETUP) begin
            to_cnt_d = '0;
        end else if ((state_q == ST_ACCESS) && !i_root_pready) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is a flop, so the
    // values computed here appear on the ports in the cycle after the edge
    // that loads them.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        prot_d      = prot_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    addr_d    = i_req_addr;
                    write_d   = i_req_write;
                    // Reads present zero write data and no byte strobes.
                    wdata_d   = i_req_write ? i_req_wdata : 32'h0;
                    strb_d    = i_req_write ? i_req_wstrb : 4'h0;
                    prot_d    = i_req_prot;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // A completing pready takes priority over the timeout.
                if (i_root_pready) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    err_d       = i_root_pslverr;
                    timeout_d   = 1'b0;
                    // Read data is only returned for error-free reads.
                    rdata_d     = (write_q || i_root_pslverr) ? 32'h0
                                                              : i_root_prdata;
                end else if (to_expire) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b1;
                    timeout_d   = 1'b1;
                    rdata_d     = 32'h0;
                end
            end

            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Ready is registered from the next state so that it is low while
        // reset is asserted and rises the cycle after reset releases.
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            addr_q      <= 32'h0;
            write_q     <= 1'b0;
            wdata_q     <= 32'h0;
            strb_q      <= 4'h0;
            prot_q      <= 3'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            prot_q      <= prot_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Without the timeout feature timeout_q can never be set, so
    // o_rsp_timeout is constant 0.
    // ------------------------------------------------------------------------
    assign o_req_ready    = req_ready_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_rdata    = rdata_q;
    assign o_rsp_err      = err_q;
    assign o_rsp_timeout  = timeout_q;

    assign o_root_psel    = psel_q;
    assign o_root_penable = penable_q;
    assign o_root_paddr   = addr_q;
    assign o_root_pwrite  = write_q;
    assign o_root_pwdata  = wdata_q;
    assign o_root_pstrb   = strb_q;
    assign o_root_pprot   = prot_q;

endmodule

// File: tb/tb_apb1_root_master.sv
module tb_apb1_root_master;

    localparam int unsigned TO_CYC = 4;
`ifdef APB1_MASTER_TIMEOUT_EN
    localparam int MAXW = 3;   // keep random transfers below the timeout
`else
    localparam int MAXW = 6;
`endif

    logic        clk = 1'b0;
    logic        prst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb1_root_master #(.TIMEOUT_CYCLES(TO_CYC), .TO_CNT_W(8)) dut (
        .i_pclk(clk), .i_prst(prst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_write(req_write),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb), .i_req_prot(req_prot),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
        .o_root_psel(psel), .o_root_paddr(paddr), .o_root_penable(penable),
        .o_root_pwdata(pwdata), .o_root_pstrb(pstrb), .o_root_pwrite(pwrite),
        .o_root_pprot(pprot), .i_root_pready(pready), .i_root_pslverr(pslverr),
        .i_root_prdata(prdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          rsp_delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference rules for the response payload.
    function automatic logic [31:0] model_rdata(input logic wr, input logic err, input logic [31:0] d);
        return (wr || err) ? 32'h0 : d;
    endfunction

    // Runs one transfer end to end, acting as the APB slave, and checks the
    // cycle-by-cycle behaviour. Inputs are driven and outputs sampled on the
    // falling edge.
    task automatic do_xfer(input vec_t v, input string tag);
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        e_wdata = v.write ? v.wdata : 32'h0;
        e_strb  = v.write ? v.strb  : 4'h0;

        chk({tag, " req_ready idle"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_addr = v.addr; req_write = v.write;
        req_wdata = v.wdata; req_wstrb = v.strb; req_prot = v.prot;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;

        // SETUP cycle
        chk({tag, " setup psel"},    {31'h0, psel},    32'h1);
        chk({tag, " setup penable"}, {31'h0, penable}, 32'h0);
        chk({tag, " setup ready"},   {31'h0, req_ready}, 32'h0);
        @(posedge clk); @(negedge clk);

        // ACCESS cycles: APB outputs must stay stable through wait states.
        for (int w = 0; w <= v.waits; w++) begin
            chk({tag, " access psel"},    {31'h0, psel},    32'h1);
            chk({tag, " access penable"}, {31'h0, penable}, 32'h1);
            chk({tag, " paddr"},  paddr,  v.addr);
            chk({tag, " pwrite"}, {31'h0, pwrite}, {31'h0, v.write});
            chk({tag, " pwdata"}, pwdata, e_wdata);
            chk({tag, " pstrb"},  {28'h0, pstrb}, {28'h0, e_strb});
            chk({tag, " pprot"},  {29'h0, pprot}, {29'h0, v.prot});
            chk({tag, " access rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
            pready  = (w == v.waits);
            pslverr = (w == v.waits) ? v.slverr : 1'($urandom);
            prdata  = (w == v.waits) ? v.prdata : $urandom;
            @(posedge clk); @(negedge clk);
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;

        // RESP: a competing request is offered and must not be taken.
        for (int d = 0; d <= v.rsp_delay; d++) begin
            chk({tag, " rsp_valid"},   {31'h0, rsp_valid}, 32'h1);
            chk({tag, " rsp_rdata"},   rsp_rdata, v.exp_rdata);
            chk({tag, " rsp_err"},     {31'h0, rsp_err}, {31'h0, v.exp_err});
            chk({tag, " rsp_timeout"}, {31'h0, rsp_timeout}, 32'h0);
            chk({tag, " resp psel"},   {31'h0, psel | penable}, 32'h0);
            chk({tag, " resp ready"},  {31'h0, req_ready}, 32'h0);
            req_valid = (d < v.rsp_delay);
            rsp_ready = (d == v.rsp_delay);
            @(posedge clk); @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk({tag, " done rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, " done psel"},      {31'h0, psel}, 32'h0);
        $display("xfer %s addr=%08h wr=%0d waits=%0d err=%0d rdata=%08h",
                 tag, v.addr, v.write, v.waits, rsp_err, rsp_rdata);
    endtask

    initial begin
        vec_t rv;
        int   acc;

        vecs[0] = '{32'h4000_0010, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, 0, 32'h0, 1'b0};
        vecs[1] = '{32'h4000_0020, 1'b0, 32'h0, 4'h0, 3'd2, 3, 1'b0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0};
        vecs[2] = '{32'h4000_0030, 1'b1, 32'h1122_3344, 4'h5, 3'd1, 1, 1'b1, 32'hFFFF_0000, 0, 32'h0, 1'b1};
        vecs[3] = '{32'h4000_0044, 1'b0, 32'h0, 4'h0, 3'd7, 0, 1'b0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h4000_0003, 1'b0, 32'h0, 4'hF, 3'd5, 2, 1'b1, 32'hFFFF_FFFF, 1, 32'h0, 1'b1};

        prst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_wstrb = '0; req_prot = '0; rsp_ready = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {req_ready, rsp_valid, psel, penable, rsp_err, rsp_timeout, pwrite},
            32'h0);
        chk("reset data", paddr | pwdata | rsp_rdata | {28'h0, pstrb} | {29'h0, pprot}, 32'h0);
        prst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ready after reset", {31'h0, req_ready}, 32'h1);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            do_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of ACCESS
        req_valid = 1'b1; req_addr = 32'h4000_0100; req_write = 1'b0; req_wstrb = 4'h0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre-reset penable", {31'h0, penable}, 32'h1);
        prst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid reset psel/penable/rsp", {29'h0, psel, penable, rsp_valid}, 32'h0);
        chk("mid reset ready", {31'h0, req_ready}, 32'h0);
        prst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post reset ready", {31'h0, req_ready}, 32'h1);
        chk("post reset psel/rsp", {30'h0, psel, rsp_valid}, 32'h0);
        $display("xfer reset-during-access done");

`ifdef APB1_MASTER_TIMEOUT_EN
        // Timeout abort: pready never rises.
        req_valid = 1'b1; req_addr = 32'h4000_0200; req_write = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        acc = 0;
        for (int c = 0; c < 40 && !rsp_valid; c++) begin
            if (psel && penable) acc++;
            prdata = $urandom;
            @(posedge clk); @(negedge clk);
        end
        chk("timeout access cycles", acc, TO_CYC);
        chk("timeout rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("timeout err", {31'h0, rsp_err}, 32'h1);
        chk("timeout flag", {31'h0, rsp_timeout}, 32'h1);
        chk("timeout rdata", rsp_rdata, 32'h0);
        chk("timeout psel", {31'h0, psel | penable}, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        $display("xfer timeout abort access_cycles=%0d", acc);
        // pready in the last allowed ACCESS cycle completes normally.
        rv = '{32'h4000_0204, 1'b0, 32'h0, 4'h0, 3'd0, TO_CYC - 1, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0};
        do_xfer(rv, "timeout-race");
`else
        // Without the timeout, a long wait must complete normally.
        acc = 0;
        rv = '{32'h4000_0208, 1'b1, 32'h5555_AAAA, 4'h3, 3'd4, 20, 1'b0, 32'h0, 0, 32'h0, 1'b0};
        do_xfer(rv, "long-wait");
`endif

        // Randomized transfers against the reference rules
        for (int i = 0; i < 30; i++) begin
            rv.addr      = $urandom;
            rv.write     = 1'($urandom);
            rv.wdata     = $urandom;
            rv.strb      = 4'($urandom);
            rv.prot      = 3'($urandom);
            rv.waits     = $urandom_range(0, MAXW);
            rv.slverr    = ($urandom_range(0, 3) == 0);
            rv.prdata    = $urandom;
            rv.rsp_delay = $urandom_range(0, 3);
            rv.exp_rdata = model_rdata(rv.write, rv.slverr, rv.prdata);
            rv.exp_err   = rv.slverr;
            do_xfer(rv, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
